set_input_stage: RTL
====================

Name: set_input_stage

Overview:
- Front end of the reference-cache lookup pipeline. It is the producer side of the set/tag lookup handshake.
- Accepts one reference-block fetch request: ref_idx, block origin in pixels, and size minus one.
- Computes how many cache lines the block spans in x and y. It then emits one beat per cache line, in raster order, to the tag read stage.
- Each beat carries the line address, the iteration indices and the request fields. Beats obey a valid/ready handshake, and the last beat of a request is flagged.

Parameters:
X_ADDR_WDTH, 12, pixel x address width
Y_ADDR_WDTH, 12, pixel y address width
C_L_H_SIZE, 3, log2 cache-line width in pixels
C_L_V_SIZE, 3, log2 cache-line height in pixels
LUMA_DIM_WDTH, 7, width of block size fields (size minus one)
REF_ADDR_WDTH, 4, reference index width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid && req_ready
req_ref_idx  in  REF_ADDR_WDTH  reference picture index
req_start_x  in  X_ADDR_WDTH  block left pixel
req_start_y  in  Y_ADDR_WDTH  block top pixel
req_wdt  in  LUMA_DIM_WDTH  block width minus one
req_hgt  in  LUMA_DIM_WDTH  block height minus one
out_valid  out  1  beat valid (feeds set_input_stage_valid)
out_ready  in  1  downstream ready (tag_compare_stage_ready_d)
curr_x  out  2  line column index within block
curr_y  out  2  line row index within block
delta_x  out  2  lines spanned in x minus one
delta_y  out  2  lines spanned in y minus one
curr_x_addr  out  X_ADDR_WDTH-C_L_H_SIZE  cache-line x address
curr_y_addr  out  Y_ADDR_WDTH-C_L_V_SIZE  cache-line y address
ref_idx_out  out  REF_ADDR_WDTH  latched req_ref_idx
start_x_out  out  X_ADDR_WDTH  latched req_start_x
start_y_out  out  Y_ADDR_WDTH  latched req_start_y
wdt_out  out  LUMA_DIM_WDTH  latched req_wdt
hgt_out  out  LUMA_DIM_WDTH  latched req_hgt
last_block  out  1  current beat is the final line of the request
busy  out  1  state is ITER
err_span  out  1  one-cycle pulse: request rejected, span exceeds 4 lines

Behaviour:
- Reset values: all outputs 0 (including out_valid and err_span); state IDLE. Reset mid-request aborts it immediately; no further beats are emitted and the pending request is discarded.
- Span arithmetic, at acceptance:
  - sx = req_start_x[C_L_H_SIZE-1:0] + req_wdt, computed in LUMA_DIM_WDTH+1 bits; dx = sx >> C_L_H_SIZE.
  - sy and dy are computed the same way from req_start_y, req_hgt and C_L_V_SIZE.
  - If dx>3 or dy>3: err_span=1 in the next cycle, no beats, state stays IDLE.
- States: IDLE and ITER.
  - IDLE: req_ready=1. On an accepted, legal request, latch the fields, set delta_x=dx and delta_y=dy, and set curr_x=curr_y=0. In the next cycle: out_valid=1, state ITER. Latency from accept to first beat is 1 cycle.
  - ITER: all beat outputs hold stable while out_valid && !out_ready.
  - On a transfer (out_valid && out_ready): if curr_x<delta_x, curr_x+1. Otherwise curr_x=0 and curr_y+1. Order is x inner, y outer.
- Line addresses:
  - curr_x_addr = start_x_out[X_ADDR_WDTH-1:C_L_H_SIZE] + curr_x; curr_y_addr is formed the same way.
  - Both are truncated to port width, so they wrap modulo 2^width at the picture address edge. No error is raised.
- last_block = (curr_x==delta_x) && (curr_y==delta_y), qualified by out_valid.
- Zero-bubble chaining:
  - In ITER, req_ready = out_valid && out_ready && last_block.
  - A request accepted in that cycle loads directly. out_valid stays 1 and the new request's first beat appears in the next cycle.
  - If no request arrives with the final transfer, go to IDLE and out_valid=0.
  - If a request accepted with the final transfer is illegal, emit err_span, go to IDLE, and out_valid=0.
- Total beats per request = (delta_x+1)*(delta_y+1), between 1 and 16.
- busy=1 exactly while in ITER.

Test Plan:
- Two-beat request: start_x=5, wdt=7, start_y=0, hgt=7, out_ready=1.
  - Response: delta_x=1, delta_y=0. Beats (0,0) then (1,0), curr_x_addr 0 then 1; last_block on beat 2. out_valid first high 1 cycle after accept.
- Maximal request: start_x=7, wdt=22, start_y=3, hgt=15, start_y line 0.
  - Response: delta_x=3, delta_y=2. 12 beats, (0,0),(1,0),(2,0),(3,0),(0,1)…(3,2). last_block only on (3,2).
- Backpressure: in the two-beat request, hold out_ready=0 for 3 cycles at beat 1.
  - Response: curr_x, curr_y, addresses and last_block stay stable. No beat is skipped or duplicated.
- Span error: start_x=7, wdt=30 (37>>3=4).
  - Response: err_span high for 1 cycle, out_valid stays 0, req_ready stays 1. The next legal request is processed normally.
- Back-to-back: request B presented with req_valid during request A's last transfer.
  - Response: req_ready=1 in that cycle. out_valid has no gap; B beat (0,0) appears in the next cycle.
- Wrap and reset: start_x=4095, wdt=7.
  - Response: curr_x_addr 511 then 0.
  - Separately, assert reset during beat 3 of the 12-beat case: out_valid=0 in the next cycle, busy=0, and no stale beats after release.

Source files
------------

// File: rtl/set_input_stage_if.sv
// rtl/set_input_stage_if.sv - request and line-beat handshake bundle for set_input_stage
interface set_input_stage_if #(
  parameter int X_ADDR_WDTH   = 12,
  parameter int Y_ADDR_WDTH   = 12,
  parameter int C_L_H_SIZE    = 3,
  parameter int C_L_V_SIZE    = 3,
  parameter int LUMA_DIM_WDTH = 7,
  parameter int REF_ADDR_WDTH = 4
);
  localparam int XL_WDTH = X_ADDR_WDTH - C_L_H_SIZE;
  localparam int YL_WDTH = Y_ADDR_WDTH - C_L_V_SIZE;

  logic                     req_valid;
  logic                     req_ready;
  logic [REF_ADDR_WDTH-1:0] req_ref_idx;
  logic [X_ADDR_WDTH-1:0]   req_start_x;
  logic [Y_ADDR_WDTH-1:0]   req_start_y;
  logic [LUMA_DIM_WDTH-1:0] req_wdt;
  logic [LUMA_DIM_WDTH-1:0] req_hgt;

  logic                     out_valid;
  logic                     out_ready;
  logic [1:0]               curr_x;
  logic [1:0]               curr_y;
  logic [1:0]               delta_x;
  logic [1:0]               delta_y;
  logic [XL_WDTH-1:0]       curr_x_addr;
  logic [YL_WDTH-1:0]       curr_y_addr;
  logic [REF_ADDR_WDTH-1:0] ref_idx_out;
  logic [X_ADDR_WDTH-1:0]   start_x_out;
  logic [Y_ADDR_WDTH-1:0]   start_y_out;
  logic [LUMA_DIM_WDTH-1:0] wdt_out;
  logic [LUMA_DIM_WDTH-1:0] hgt_out;
  logic                     last_block;
  logic                     busy;
  logic                     err_span;

  modport master (
    input  req_valid, req_ref_idx, req_start_x, req_start_y, req_wdt, req_hgt, out_ready,
    output req_ready, out_valid, curr_x, curr_y, delta_x, delta_y, curr_x_addr, curr_y_addr,
           ref_idx_out, start_x_out, start_y_out, wdt_out, hgt_out, last_block, busy, err_span
  );

  modport slave (
    output req_valid, req_ref_idx, req_start_x, req_start_y, req_wdt, req_hgt, out_ready,
    input  req_ready, out_valid, curr_x, curr_y, delta_x, delta_y, curr_x_addr, curr_y_addr,
           ref_idx_out, start_x_out, start_y_out, wdt_out, hgt_out, last_block, busy, err_span
  );
endinterface

// File: rtl/set_input_stage.sv
// rtl/set_input_stage.sv - splits a reference-block fetch into raster-ordered cache-line beats
module set_input_stage #(
  parameter int X_ADDR_WDTH   = 12,
  parameter int Y_ADDR_WDTH   = 12,
  parameter int C_L_H_SIZE    = 3,
  parameter int C_L_V_SIZE    = 3,
  parameter int LUMA_DIM_WDTH = 7,
  parameter int REF_ADDR_WDTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  set_input_stage_if.master  bus
);
  localparam int SPAN_WDTH = LUMA_DIM_WDTH + 1;
  localparam int XL_WDTH   = X_ADDR_WDTH - C_L_H_SIZE;
  localparam int YL_WDTH   = Y_ADDR_WDTH - C_L_V_SIZE;

  typedef enum logic {IDLE, ITER} state_t;
  state_t state, state_nxt;

  logic [SPAN_WDTH-1:0]     span_x, span_y, lines_x, lines_y;
  logic                     span_ok, transfer, last_beat, req_ready_int, accept, load;
  logic [1:0]               curr_x_q, curr_y_q, delta_x_q, delta_y_q;
  logic [REF_ADDR_WDTH-1:0] ref_idx_q;
  logic [X_ADDR_WDTH-1:0]   start_x_q;
  logic [Y_ADDR_WDTH-1:0]   start_y_q;
  logic [LUMA_DIM_WDTH-1:0] wdt_q, hgt_q;
  logic                     err_span_q;

  // Offset within the first line plus size-1 gives the last pixel; its line index is the span-1.
  assign span_x  = SPAN_WDTH'(bus.req_start_x[C_L_H_SIZE-1:0]) + SPAN_WDTH'(bus.req_wdt);
  assign span_y  = SPAN_WDTH'(bus.req_start_y[C_L_V_SIZE-1:0]) + SPAN_WDTH'(bus.req_hgt);
  assign lines_x = span_x >> C_L_H_SIZE;
  assign lines_y = span_y >> C_L_V_SIZE;
  assign span_ok = (lines_x < SPAN_WDTH'(4)) && (lines_y < SPAN_WDTH'(4));

  assign transfer  = (state == ITER) && bus.out_ready;
  assign last_beat = (curr_x_q == delta_x_q) && (curr_y_q == delta_y_q);

  // A new request may ride on the final transfer so the beat stream has no bubble.
  assign req_ready_int = !reset && ((state == IDLE) || (transfer && last_beat));
  assign accept        = bus.req_valid && req_ready_int;
  assign load          = accept && span_ok;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load) state_nxt = ITER;
      ITER:    if (transfer && last_beat && !load) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      curr_x_q   <= '0;
      curr_y_q   <= '0;
      delta_x_q  <= '0;
      delta_y_q  <= '0;
      ref_idx_q  <= '0;
      start_x_q  <= '0;
      start_y_q  <= '0;
      wdt_q      <= '0;
      hgt_q      <= '0;
      err_span_q <= 1'b0;
    end else begin
      err_span_q <= accept && !span_ok;
      if (load) begin
        curr_x_q  <= '0;
        curr_y_q  <= '0;
        delta_x_q <= lines_x[1:0];
        delta_y_q <= lines_y[1:0];
        ref_idx_q <= bus.req_ref_idx;
        start_x_q <= bus.req_start_x;
        start_y_q <= bus.req_start_y;
        wdt_q     <= bus.req_wdt;
        hgt_q     <= bus.req_hgt;
      end else if (transfer && !last_beat) begin
        if (curr_x_q < delta_x_q) begin
          curr_x_q <= curr_x_q + 2'd1;
        end else begin
          curr_x_q <= '0;
          curr_y_q <= curr_y_q + 2'd1;
        end
      end
    end
  end

  assign bus.req_ready   = req_ready_int;
  assign bus.out_valid   = (state == ITER);
  assign bus.busy        = (state == ITER);
  assign bus.curr_x      = curr_x_q;
  assign bus.curr_y      = curr_y_q;
  assign bus.delta_x     = delta_x_q;
  assign bus.delta_y     = delta_y_q;
  // Line addresses wrap silently at the picture edge.
  assign bus.curr_x_addr = start_x_q[X_ADDR_WDTH-1:C_L_H_SIZE] + XL_WDTH'(curr_x_q);
  assign bus.curr_y_addr = start_y_q[Y_ADDR_WDTH-1:C_L_V_SIZE] + YL_WDTH'(curr_y_q);
  assign bus.ref_idx_out = ref_idx_q;
  assign bus.start_x_out = start_x_q;
  assign bus.start_y_out = start_y_q;
  assign bus.wdt_out     = wdt_q;
  assign bus.hgt_out     = hgt_q;
  assign bus.last_block  = (state == ITER) && last_beat;
  assign bus.err_span    = err_span_q;
endmodule
